cnt_valley_hold: RTL

Minimum-tracking hold counter with windowed report output. It is the mirror of the peak-hold/decay counter: it loads a new sample only when the sample is lower than the held value, and otherwise rises toward full scale. It also publishes a snapshot of the held value once every WINDOW enabled samples over a valid/ready handshake. Typical use: the consumer-side valley detector feeding a stats collector in the pyrope compiler regression designs.

---
 rtl/cnt_valley_hold.sv | 125 ++++++++++++
 1 files changed

// File: rtl/cnt_valley_hold.sv
// Purpose : minimum-tracking hold counter with a windowed snapshot report.
// Latency : out_o is 1 cycle after the sample; rpt_valid_o rises on the edge that captures the closing sample.
// Backpressure: one report slot; a close while full and not accepted drops the new snapshot and counts it.
//
// Ports:
//   clk_i        rising-edge clock
//   rst_ni       asynchronous active-low reset
//   cond_i       sample enable
//   inp_i        sample value (unsigned)
//   out_o        held minimum x (registered)
//   rpt_valid_o  report pending
//   rpt_ready_i  consumer accepts the report
//   rpt_data_o   report snapshot (stable while valid and not ready)
//   rpt_drop_o   dropped-report count, saturating at 255

module cnt_valley_hold #(
    parameter int WIDTH  = 16,
    parameter int WINDOW = 8,
    parameter int STEP   = 1
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             cond_i,
    input  logic [WIDTH-1:0] inp_i,
    output logic [WIDTH-1:0] out_o,
    output logic             rpt_valid_o,
    input  logic             rpt_ready_i,
    output logic [WIDTH-1:0] rpt_data_o,
    output logic [7:0]       rpt_drop_o
);

    localparam int                CW       = $clog2(WINDOW);
    localparam logic [CW-1:0]     CNT_LAST = CW'(WINDOW - 1);
    localparam logic [WIDTH:0]    STEP_X   = (WIDTH + 1)'(STEP);
    localparam logic [WIDTH-1:0]  X_MAX    = '1;

    typedef enum logic {
        EMPTY = 1'b0,
        FULL  = 1'b1
    } rpt_state_e;

    logic [WIDTH-1:0] x_q, x_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    rpt_state_e       state_q, state_d;
    logic [WIDTH-1:0] data_q, data_d;
    logic [7:0]       drop_q, drop_d;

    logic [WIDTH:0]   rise_sum;
    logic [WIDTH-1:0] x_upd;
    logic             close;

    // Sample datapath: load on a strictly lower sample, otherwise rise.
    // The sum carries one extra bit so the rise clamps at full scale
    // instead of wrapping; STEP < 2^WIDTH keeps the carry a single bit.
    always_comb begin
        rise_sum = {1'b0, x_q} + STEP_X;
        if (inp_i < x_q) begin
            x_upd = inp_i;
        end else if (rise_sum[WIDTH]) begin
            x_upd = X_MAX;
        end else begin
            x_upd = rise_sum[WIDTH-1:0];
        end

        close = cond_i && (cnt_q == CNT_LAST);

        x_d   = x_q;
        cnt_d = cnt_q;
        if (cond_i) begin
            x_d   = x_upd;
            cnt_d = close ? '0 : cnt_q + CW'(1);
        end
    end

    // Report slot. The snapshot is the post-update value of the closing
    // sample, so it is taken from x_upd rather than x_q.
    always_comb begin
        state_d = state_q;
        data_d  = data_q;
        drop_d  = drop_q;
        unique case (state_q)
            EMPTY: begin
                if (close) begin
                    data_d  = x_upd;
                    state_d = FULL;
                end
            end
            FULL: begin
                if (close) begin
                    if (rpt_ready_i) begin
                        // Old report leaves this edge, new one takes the slot.
                        data_d = x_upd;
                    end else if (drop_q != 8'hFF) begin
                        drop_d = drop_q + 8'd1;
                    end
                end else if (rpt_ready_i) begin
                    state_d = EMPTY;
                end
            end
            default: state_d = EMPTY;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            x_q     <= X_MAX;
            cnt_q   <= '0;
            state_q <= EMPTY;
            data_q  <= '0;
            drop_q  <= '0;
        end else begin
            x_q     <= x_d;
            cnt_q   <= cnt_d;
            state_q <= state_d;
            data_q  <= data_d;
            drop_q  <= drop_d;
        end
    end

    assign out_o       = x_q;
    assign rpt_valid_o = (state_q == FULL);
    assign rpt_data_o  = data_q;
    assign rpt_drop_o  = drop_q;

endmodule
